// File: rtl/llr_frame_pkg.sv
// Shared types and helpers for the LLR frame assembler: issue FSM state
// encoding, ping-pong bank index type and the symbol counter width.
package llr_frame_pkg;

    // Issue FSM: wait for a full bank, present it for one cycle, then hold
    // the bank until the decoder reports completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } issue_state_t;

    // Index into the two-bank ping-pong buffer.
    typedef logic bank_t;

    // Width of the symbol counter that walks 0..symbols-1.
    function automatic int sym_cnt_width(input int symbols);
        return (symbols > 1) ? $clog2(symbols) : 1;
    endfunction

endpackage

// File: rtl/llr_frame_assembler_clip.sv
// llr_clip: saturates one IEEE-float LLR to a fixed magnitude while keeping
// its sign. The compare is done on the raw magnitude bits, so NaNs (whose
// magnitude pattern exceeds any finite value) are clipped like large values.
module llr_clip #(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] CLIP_MAG = 32'h4100_0000
) (
    input  logic [BITS-1:0] llr,
    output logic [BITS-1:0] clipped
);

    // Replace an over-range magnitude by CLIP_MAG, sign bit untouched.
    always_comb begin
        clipped = llr;
        if (llr[BITS-2:0] > CLIP_MAG[BITS-2:0]) begin
            clipped = {llr[BITS-1], CLIP_MAG[BITS-2:0]};
        end else begin
            clipped = llr;
        end
    end

endmodule

// File: rtl/llr_frame_assembler.sv
// llr_frame_assembler: collects SYMBOLS symbols of BITS_PER_SYMBOL LLRs into
// a two-bank ping-pong buffer and hands each complete frame to the decoder
// as a one-cycle out_valid / LLRVector transfer. A bank stays occupied until
// the decoder raises dec_done, so at most two complete frames are buffered.
//
// Optional feature: define LLR_FRAME_CLIP_EN to saturate every accepted LLR
// to +/-CLIP_MAG on the write path (no added latency). Without the macro the
// LLR bit patterns are stored and issued unchanged.
module llr_frame_assembler
    import llr_frame_pkg::*;
#(
    parameter int              BITS            = 32,
    parameter int              BITS_PER_SYMBOL = 2,
    parameter int              SYMBOLS         = 5,
    parameter logic [BITS-1:0] CLIP_MAG        = 32'h4100_0000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [BITS_PER_SYMBOL-1:0][BITS-1:0]          s_llr,
    input  logic                                          s_last,
    input  logic                                          dec_done,
    output logic                                          out_valid,
    output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] LLRVector,
    output logic                                          frame_err
);

    localparam int            CW       = sym_cnt_width(SYMBOLS);
    localparam logic [CW-1:0] LAST_IDX = CW'(SYMBOLS - 1);

    typedef logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] frame_t;

    // Buffer state
    frame_t        bank_mem_r [2];
    logic [1:0]    bank_full_r;
    bank_t         wr_bank_r;
    bank_t         rd_bank_r;
    logic [CW-1:0] sym_cnt_r;

    // Issue FSM
    issue_state_t  state_r;
    issue_state_t  state_next_s;
    logic          issue_s;

    // Write-path decode
    logic [BITS_PER_SYMBOL-1:0][BITS-1:0] wr_data_s;
    logic          accept_s;
    logic          last_sym_s;
    logic          complete_s;
    logic          short_s;
    logic          release_s;

    // ------------------------------------------------------------------
    // Write data path: optional per-LLR saturation
    // ------------------------------------------------------------------
    genvar gb;
    generate
        for (gb = 0; gb < BITS_PER_SYMBOL; gb++) begin : g_wr
`ifdef LLR_FRAME_CLIP_EN
            llr_clip #(
                .BITS     (BITS),
                .CLIP_MAG (CLIP_MAG)
            ) u_clip (
                .llr     (s_llr[gb]),
                .clipped (wr_data_s[gb])
            );
`else
            assign wr_data_s[gb] = s_llr[gb];
`endif
        end
    endgenerate

`ifndef LLR_FRAME_CLIP_EN
    // CLIP_MAG only matters when saturation is compiled in.
    logic unused_clip_mag_s;
    assign unused_clip_mag_s = ^CLIP_MAG;
`endif

    // ------------------------------------------------------------------
    // Handshake and framing decode
    // ------------------------------------------------------------------
    // The write bank is free exactly when it is not holding a full frame.
    assign s_ready    = ~bank_full_r[wr_bank_r];
    assign accept_s   = s_valid & s_ready;
    assign last_sym_s = (sym_cnt_r == LAST_IDX);
    // Full-length frame: always kept, even if s_last was missing.
    assign complete_s = accept_s & last_sym_s;
    // Early s_last: the partial frame is dropped.
    assign short_s    = accept_s & s_last & ~last_sym_s;
    // Decoder finished the issued bank; only honoured while waiting for it.
    assign release_s  = (state_r == BUSY) & dec_done;

    // Symbol counter, write-bank pointer and registered framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_r <= '0;
            wr_bank_r <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (complete_s & ~s_last) | short_s;
            if (complete_s) begin
                sym_cnt_r <= '0;
                wr_bank_r <= ~wr_bank_r;
            end else if (short_s) begin
                sym_cnt_r <= '0;
            end else if (accept_s) begin
                sym_cnt_r <= sym_cnt_r + CW'(1);
            end
        end
    end

    // Bank storage: each accepted symbol lands in its slot of the write bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_mem_r[0] <= '0;
            bank_mem_r[1] <= '0;
        end else if (accept_s) begin
            for (int s = 0; s < SYMBOLS; s++) begin
                if (sym_cnt_r == CW'(s)) begin
                    for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
                        bank_mem_r[wr_bank_r][b][s] <= wr_data_s[b];
                    end
                end
            end
        end
    end

    // Bank occupancy: set on frame completion, cleared on decoder release.
    // The two events always target different banks, so both may land at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full_r <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (complete_s && (wr_bank_r == 1'(k))) begin
                    bank_full_r[k] <= 1'b1;
                end else if (release_s && (rd_bank_r == 1'(k))) begin
                    bank_full_r[k] <= 1'b0;
                end
            end
        end
    end

    // Read-bank pointer advances when the decoder releases the current bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_r <= 1'b0;
        end else if (release_s) begin
            rd_bank_r <= ~rd_bank_r;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; dec_done outside BUSY has no effect.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bank_full_r[rd_bank_r]) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = BUSY;
            end
            BUSY: begin
                if (dec_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the next state so that the registered
    // outputs below are high exactly while the state register reads ISSUE.
    always_comb begin
        issue_s = 1'b0;
        case (state_next_s)
            ISSUE:   issue_s = 1'b1;
            default: issue_s = 1'b0;
        endcase
    end

    // Registered decoder interface: frame visible only in the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            LLRVector <= '0;
        end else begin
            out_valid <= issue_s;
            if (issue_s) begin
                LLRVector <= bank_mem_r[rd_bank_r];
            end else begin
                LLRVector <= '0;
            end
        end
    end

endmodule

// File: tb/tb_llr_frame_assembler.sv
// Self-checking bench for llr_frame_assembler: directed scenarios with a few
// literal expectations plus randomized traffic, all checked every cycle
// against a frame-queue model of the buffer and decoder hand-off.
module tb_llr_frame_assembler;

    localparam int BITS = 32;
    localparam int BPS  = 2;
    localparam int SYM  = 5;
    localparam int FW   = BPS * SYM * BITS;

    typedef logic [BPS-1:0][SYM-1:0][BITS-1:0] frame_t;

    localparam logic [BITS-1:0] P2   = 32'h4000_0000;  //  2.0
    localparam logic [BITS-1:0] N2   = 32'hC000_0000;  // -2.0
    localparam logic [BITS-1:0] P20  = 32'h41A0_0000;  //  20.0
    localparam logic [BITS-1:0] N100 = 32'hC2C8_0000;  // -100.0

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic dec_done = 1'b0;
    logic [BPS-1:0][BITS-1:0] s_llr = '0;
    logic s_ready;
    logic out_valid;
    logic frame_err;
    frame_t LLRVector;

    int checks = 0;
    int errors = 0;

    llr_frame_assembler #(
        .BITS            (BITS),
        .BITS_PER_SYMBOL (BPS),
        .SYMBOLS         (SYM),
        .CLIP_MAG        (32'h4100_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_llr     (s_llr),
        .s_last    (s_last),
        .dec_done  (dec_done),
        .out_valid (out_valid),
        .LLRVector (LLRVector),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stored value of one LLR.
    function automatic logic [BITS-1:0] clip_ref(input logic [BITS-1:0] v);
`ifdef LLR_FRAME_CLIP_EN
        if ((v & 32'h7FFF_FFFF) > 32'h4100_0000) return (v & 32'h8000_0000) | 32'h4100_0000;
`endif
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    // m_q holds complete frames in arrival order; the front one is the frame
    // owned by the decoder (or about to be). Capacity is two frames.
    frame_t m_q[$];
    frame_t m_part = '0;
    int     m_cnt = 0;
    bit     m_inflight = 1'b0;  // front frame handed to decoder, done not seen
    bit     m_ov = 1'b0;
    bit     m_fe = 1'b0;
    frame_t m_vec = '0;

    bit     mt_acc, mt_pop, mt_push, mt_ov, mt_fe;
    frame_t mt_vec;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_inflight = 1'b0;
            m_ov = 1'b0;
            m_fe = 1'b0;
            m_vec = '0;
        end else begin
            mt_acc = s_valid && (m_q.size() < 2);
            mt_pop = 1'b0;
            mt_push = 1'b0;
            mt_ov = 1'b0;
            mt_fe = 1'b0;
            mt_vec = '0;
            if (m_ov) begin
                // frame being presented this cycle; done is ignored
            end else if (m_inflight) begin
                if (dec_done) begin
                    mt_pop = 1'b1;
                    m_inflight = 1'b0;
                end
            end else if (m_q.size() > 0) begin
                mt_ov = 1'b1;
                mt_vec = m_q[0];
                m_inflight = 1'b1;
            end
            if (mt_acc) begin
                for (int b = 0; b < BPS; b++) m_part[b][m_cnt] = clip_ref(s_llr[b]);
                if (m_cnt == SYM - 1) begin
                    mt_push = 1'b1;
                    mt_fe = !s_last;
                    m_cnt = 0;
                end else if (s_last) begin
                    mt_fe = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (mt_pop) void'(m_q.pop_front());
            if (mt_push) m_q.push_back(m_part);
            m_ov = mt_ov;
            m_fe = mt_fe;
            m_vec = mt_vec;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", s_ready, (m_q.size() < 2));
            chk("out_valid", out_valid, m_ov);
            chk("frame_err", frame_err, m_fe);
            chk("LLRVector", LLRVector, m_ov ? m_vec : '0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_sym(input logic [BITS-1:0] l0, input logic [BITS-1:0] l1, input logic last);
        int guard = 0;
        @(negedge clk); #1;
        s_valid = 1'b1;
        s_llr[0] = l0;
        s_llr[1] = l1;
        s_last = last;
        while (!s_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_sym_timeout: s_ready stayed 0 for %0d cycles, expected 1", guard);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit last_at_end);
        for (int k = 0; k < n; k++) send_sym($urandom, $urandom, last_at_end && (k == n - 1));
    endtask

    task automatic pulse_done();
        @(negedge clk); #1;
        dec_done = 1'b1;
        @(posedge clk); #1;
        dec_done = 1'b0;
    endtask

    task automatic watch(input int n, output int ov, output int fe);
        ov = 0;
        fe = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) ov++;
            if (frame_err) fe++;
        end
    endtask

    logic [BITS-1:0] t0 [SYM];
    logic [BITS-1:0] t1 [SYM];
    frame_t exp_f;
    int ov_n, fe_n, guard;

    initial begin
        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("reset_s_ready", s_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_llrvector", LLRVector, '0);
        #1 rst = 1'b0;

        // ---- single frame ----
        t0 = '{P2, N2, N2, P2, N2};
        t1 = '{P2, P2, N2, P2, P2};
        for (int k = 0; k < SYM; k++) begin
            exp_f[0][k] = t0[k];
            exp_f[1][k] = t1[k];
        end
        for (int k = 0; k < SYM; k++) send_sym(t0[k], t1[k], k == SYM - 1);
        @(negedge clk);
        chk("single_ov_after_1_edge", out_valid, 1'b0);
        @(negedge clk);
        chk("single_ov_after_2_edges", out_valid, 1'b1);
        chk("single_vec", LLRVector, exp_f);
        @(negedge clk);
        chk("single_vec_zero_after", LLRVector, '0);
        pulse_done();
        repeat (3) @(negedge clk);

        // ---- back-pressure ----
        send_frame(SYM, 1'b1);
        send_frame(SYM, 1'b1);
        @(negedge clk);
        chk("bp_ready_low", s_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("bp_ready_still_low", s_ready, 1'b0);
        pulse_done();
        @(negedge clk);
        chk("bp_ready_rise", s_ready, 1'b1);
        chk("bp_ov_1_edge", out_valid, 1'b0);
        @(negedge clk);
        chk("bp_ov_2_edges", out_valid, 1'b1);
        watch(4, ov_n, fe_n);
        chk("bp_no_duplicate", ov_n, 0);
        send_frame(SYM, 1'b1);
        pulse_done();
        watch(4, ov_n, fe_n);
        chk("bp_frame3_issued", ov_n, 1);
        pulse_done();
        repeat (3) @(negedge clk);

        // ---- framing errors ----
        send_frame(3, 1'b1);
        watch(6, ov_n, fe_n);
        chk("short_frame_err", fe_n, 1);
        chk("short_no_issue", ov_n, 0);
        send_frame(SYM, 1'b1);
        watch(6, ov_n, fe_n);
        chk("clean_after_short_issue", ov_n, 1);
        chk("clean_after_short_noerr", fe_n, 0);
        pulse_done();
        send_frame(SYM, 1'b0);
        watch(6, ov_n, fe_n);
        chk("missing_last_err", fe_n, 1);
        chk("missing_last_issue", ov_n, 1);
        pulse_done();
        repeat (3) @(negedge clk);

        // ---- completion coincides with release ----
        send_frame(SYM, 1'b1);
        send_frame(SYM - 1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        s_valid = 1'b1;
        s_llr[0] = $urandom;
        s_llr[1] = $urandom;
        s_last = 1'b1;
        dec_done = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        dec_done = 1'b0;
        watch(6, ov_n, fe_n);
        chk("simul_one_issue", ov_n, 1);
        pulse_done();
        watch(5, ov_n, fe_n);
        chk("simul_no_extra", ov_n, 0);

        // ---- reset while busy ----
        send_frame(SYM, 1'b1);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstbusy_s_ready", s_ready, 1'b1);
        chk("rstbusy_out_valid", out_valid, 1'b0);
        chk("rstbusy_frame_err", frame_err, 1'b0);
        chk("rstbusy_llrvector", LLRVector, '0);
        #1 rst = 1'b0;
        pulse_done();
        watch(5, ov_n, fe_n);
        chk("rstbusy_done_ignored", ov_n, 0);
        send_frame(SYM, 1'b1);
        watch(5, ov_n, fe_n);
        chk("rstbusy_fresh_issue", ov_n, 1);
        pulse_done();
        repeat (2) @(negedge clk);

        // ---- clip / pass-through ----
        send_sym(P20, N100, 1'b0);
        for (int k = 1; k < SYM; k++) send_sym(P2, N2, k == SYM - 1);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("clip_issue_seen", out_valid, 1'b1);
`ifdef LLR_FRAME_CLIP_EN
        chk("clip_pos", LLRVector[0][0], 32'h4100_0000);
        chk("clip_neg", LLRVector[1][0], 32'hC100_0000);
`else
        chk("pass_pos", LLRVector[0][0], P20);
        chk("pass_neg", LLRVector[1][0], N100);
`endif
        pulse_done();
        repeat (2) @(negedge clk);

        // ---- randomized traffic ----
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            rst = (($urandom % 900) == 0);
            s_valid = (($urandom % 4) != 0);
            for (int b = 0; b < BPS; b++) begin
                s_llr[b] = (($urandom % 3) == 0) ? ($urandom & 32'hC0FF_FFFF) : $urandom;
            end
            if (m_cnt == SYM - 1) s_last = (($urandom % 8) != 0);
            else s_last = (($urandom % 16) == 0);
            dec_done = (($urandom % 5) == 0);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        dec_done = 1'b1;
        repeat (20) @(negedge clk);
        #1 dec_done = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
